// File: rtl/booth_r4_seq_mul_if.sv
// Handshake and operand/result bundle for the iterative radix-4 Booth multiplier.
interface booth_r4_seq_mul_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mulcand;
  logic [WIDTH-1:0]   mulplier;
  logic               sign;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, mulcand, mulplier, sign, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mulcand, mulplier, sign, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, one operation in flight.
// Optional macro BOOTH_EARLY_TERM_EN finishes as soon as the remaining multiplier digits are all zero.
module booth_r4_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_r4_seq_mul_if.slave    bus
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int IW = $clog2(N);
  localparam int PW = WIDTH + 3;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [WIDTH+2:0]     mreg;
  logic [WIDTH+1:0]     mext;
  logic [2*WIDTH-1:0]   acc;
  logic [IW-1:0]        iter;
  logic                 out_valid_reg;
  logic                 busy_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [PW-1:0]        mext_x;
  logic [PW-1:0]        pp;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   sum;
  logic                 early_done;
  logic                 ext_bit;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.product   = product_reg;

  assign ext_bit = bus.sign & bus.mulplier[WIDTH-1];

  // Booth digit select on the low triplet of the shifting multiplier.
  always_comb begin
    mext_x = {mext[WIDTH+1], mext};
    pp     = '0;
    case (mreg[2:0])
      3'b001, 3'b010: pp = mext_x;
      3'b011:         pp = mext_x << 1;
      3'b100:         pp = ~(mext_x << 1) + PW'(1);
      3'b101, 3'b110: pp = ~mext_x + PW'(1);
      default:        pp = '0;
    endcase
    pp_ext     = {{(2*WIDTH-PW){pp[PW-1]}}, pp};
    sum        = acc + (pp_ext << {iter, 1'b0});
    early_done = EARLY_TERM && ((mreg == '0) || (&mreg));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      product_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mreg     <= {ext_bit, ext_bit, bus.mulplier, 1'b0};
            mext     <= bus.sign ? {{2{bus.mulcand[WIDTH-1]}}, bus.mulcand}
                                 : {2'b00, bus.mulcand};
            acc      <= '0;
            iter     <= '0;
            busy_reg <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (early_done) begin
            product_reg   <= acc;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            acc  <= sum;
            mreg <= {mreg[WIDTH+2], mreg[WIDTH+2], mreg[WIDTH+2:2]};
            iter <= iter + IW'(1);
            if (iter == IW'(N - 1)) begin
              product_reg   <= sum;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
